// File: rtl/rtable_pkg.sv
// ============================================================================
// Module      : rtable_pkg
// Description : Shared action codes, move decode, class enum and default
//               rewards for the grid-world reward/transition unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rtable_pkg;

    localparam logic [2:0] c_act_w  = 3'd0;
    localparam logic [2:0] c_act_nw = 3'd1;
    localparam logic [2:0] c_act_n  = 3'd2;
    localparam logic [2:0] c_act_ne = 3'd3;
    localparam logic [2:0] c_act_e  = 3'd4;
    localparam logic [2:0] c_act_se = 3'd5;
    localparam logic [2:0] c_act_s  = 3'd6;
    localparam logic [2:0] c_act_sw = 3'd7;

    localparam int c_wall_reward_def = -255;
    localparam int c_goal_reward_def = 255;
    localparam int c_step_reward_def = 0;

    typedef enum logic [1:0] {
        CLS_STEP    = 2'd0,
        CLS_WALL    = 2'd1,
        CLS_GOAL    = 2'd2,
        CLS_SPECIAL = 2'd3
    } class_e;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } move_t;

    // y grows downward, so "north" is dy = -1
    function automatic move_t action_delta(input logic [2:0] act);
        move_t m;
        m = '0;
        case (act)
            c_act_w:  begin m.dx = -2'sd1; m.dy =  2'sd0; end
            c_act_nw: begin m.dx = -2'sd1; m.dy = -2'sd1; end
            c_act_n:  begin m.dx =  2'sd0; m.dy = -2'sd1; end
            c_act_ne: begin m.dx =  2'sd1; m.dy = -2'sd1; end
            c_act_e:  begin m.dx =  2'sd1; m.dy =  2'sd0; end
            c_act_se: begin m.dx =  2'sd1; m.dy =  2'sd1; end
            c_act_s:  begin m.dx =  2'sd0; m.dy =  2'sd1; end
            c_act_sw: begin m.dx = -2'sd1; m.dy =  2'sd1; end
            default:  m = '0;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rtable_special_cam.sv
// ============================================================================
// Module      : rtable_special_cam
// Description : Programmable special-reward cells with a parallel match;
//               the lowest enabled matching index supplies the value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtable_special_cam
    import rtable_pkg::*;
#(
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SPECIAL = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [3:0]            i_idx,
    input  logic [X_BITS-1:0]     i_cfg_x,
    input  logic [Y_BITS-1:0]     i_cfg_y,
    input  logic [DATA_WIDTH-1:0] i_cfg_data,
    input  logic                  i_cfg_en,
    input  logic [X_BITS-1:0]     i_look_x,
    input  logic [Y_BITS-1:0]     i_look_y,
    output logic                  o_hit,
    output logic [DATA_WIDTH-1:0] o_value
);

    logic [X_BITS-1:0]     r_x   [NUM_SPECIAL];
    logic [Y_BITS-1:0]     r_y   [NUM_SPECIAL];
    logic [DATA_WIDTH-1:0] r_val [NUM_SPECIAL];
    logic                  r_en  [NUM_SPECIAL];
    logic [NUM_SPECIAL-1:0] w_match;
    logic                  w_wr;

    assign w_wr = i_we && ({1'b0, i_idx} < 5'(NUM_SPECIAL));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_SPECIAL; i++) begin
                r_x[i]   <= '0;
                r_y[i]   <= '0;
                r_val[i] <= '0;
                r_en[i]  <= 1'b0;
            end
        end else if (w_wr) begin
            for (int i = 0; i < NUM_SPECIAL; i++) begin
                if (i_idx == 4'(i)) begin
                    r_x[i]   <= i_cfg_x;
                    r_y[i]   <= i_cfg_y;
                    r_val[i] <= i_cfg_data;
                    r_en[i]  <= i_cfg_en;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_SPECIAL; g++) begin : g_match
            assign w_match[g] = r_en[g] && (r_x[g] == i_look_x) && (r_y[g] == i_look_y);
        end
    endgenerate

    // Scan high-to-low so the lowest matching index is the final assignment
    always_comb begin
        o_hit   = 1'b0;
        o_value = '0;
        for (int i = NUM_SPECIAL - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit   = 1'b1;
                o_value = r_val[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rtable_grid.sv
// ============================================================================
// Module      : rtable_grid
// Description : Two-stage reward/transition unit for an 8-connected grid.
//               Optional RTABLE_GRID_STATS_EN adds wall/goal result counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtable_grid
    import rtable_pkg::*;
#(
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SPECIAL = 4,
    parameter int WALL_REWARD = c_wall_reward_def,
    parameter int GOAL_REWARD = c_goal_reward_def,
    parameter int STEP_REWARD = c_step_reward_def
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [X_BITS-1:0]     i_x,
    input  logic [Y_BITS-1:0]     i_y,
    input  logic [2:0]            i_action,
    input  logic                  i_ready,
    input  logic                  i_cfg_we,
    input  logic                  i_cfg_sel,
    input  logic [3:0]            i_cfg_idx,
    input  logic [X_BITS-1:0]     i_cfg_x,
    input  logic [Y_BITS-1:0]     i_cfg_y,
    input  logic [DATA_WIDTH-1:0] i_cfg_data,
    input  logic                  i_cfg_en,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_class,
    output logic [X_BITS-1:0]     o_next_x,
    output logic [Y_BITS-1:0]     o_next_y
`ifdef RTABLE_GRID_STATS_EN
    ,
    output logic [31:0]           o_wall_cnt,
    output logic [31:0]           o_goal_cnt
`endif
);

    localparam logic [X_BITS-1:0]     c_x_max = '1;
    localparam logic [Y_BITS-1:0]     c_y_max = '1;
    localparam logic [DATA_WIDTH-1:0] c_wall  = DATA_WIDTH'(WALL_REWARD);
    localparam logic [DATA_WIDTH-1:0] c_goal  = DATA_WIDTH'(GOAL_REWARD);
    localparam logic [DATA_WIDTH-1:0] c_step  = DATA_WIDTH'(STEP_REWARD);

    logic                  w_en;
    move_t                 w_move;
    logic                  w_wall;
    logic                  w_goal_hit;
    logic [X_BITS-1:0]     w_next_x;
    logic [Y_BITS-1:0]     w_next_y;
    logic                  w_cam_hit;
    logic [DATA_WIDTH-1:0] w_cam_value;
    class_e                w_class;
    logic [DATA_WIDTH-1:0] w_reward;

    logic [X_BITS-1:0]     r_goal_x;
    logic [Y_BITS-1:0]     r_goal_y;

    logic                  r_valid1;
    class_e                r_class1;
    logic [X_BITS-1:0]     r_nx1;
    logic [Y_BITS-1:0]     r_ny1;
    logic [DATA_WIDTH-1:0] r_sval1;

    logic                  r_valid2;
    class_e                r_class2;
    logic [DATA_WIDTH-1:0] r_data2;
    logic [X_BITS-1:0]     r_nx2;
    logic [Y_BITS-1:0]     r_ny2;

    assign w_en    = !r_valid2 || i_ready;
    assign o_ready = w_en;

    assign w_move = action_delta(i_action);
    assign w_wall = ((w_move.dx == -2'sd1) && (i_x == '0))
                 || ((w_move.dx ==  2'sd1) && (i_x == c_x_max))
                 || ((w_move.dy == -2'sd1) && (i_y == '0))
                 || ((w_move.dy ==  2'sd1) && (i_y == c_y_max));

    always_comb begin
        w_next_x = i_x;
        w_next_y = i_y;
        if (!w_wall) begin
            if (w_move.dx == -2'sd1)     w_next_x = i_x - X_BITS'(1);
            else if (w_move.dx == 2'sd1) w_next_x = i_x + X_BITS'(1);
            if (w_move.dy == -2'sd1)     w_next_y = i_y - Y_BITS'(1);
            else if (w_move.dy == 2'sd1) w_next_y = i_y + Y_BITS'(1);
        end
    end

    assign w_goal_hit = (w_next_x == r_goal_x) && (w_next_y == r_goal_y)
                     && !((i_x == r_goal_x) && (i_y == r_goal_y));

    rtable_special_cam #(
        .X_BITS      (X_BITS),
        .Y_BITS      (Y_BITS),
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_SPECIAL (NUM_SPECIAL)
    ) u_cam (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_we       (i_cfg_we && i_cfg_sel),
        .i_idx      (i_cfg_idx),
        .i_cfg_x    (i_cfg_x),
        .i_cfg_y    (i_cfg_y),
        .i_cfg_data (i_cfg_data),
        .i_cfg_en   (i_cfg_en),
        .i_look_x   (w_next_x),
        .i_look_y   (w_next_y),
        .o_hit      (w_cam_hit),
        .o_value    (w_cam_value)
    );

    always_comb begin
        w_class = CLS_STEP;
        if (w_wall)          w_class = CLS_WALL;
        else if (w_goal_hit) w_class = CLS_GOAL;
        else if (w_cam_hit)  w_class = CLS_SPECIAL;
    end

    // Config registers update at the same edge that captures a lookup,
    // so a lookup accepted alongside a write decodes against the old goal
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_goal_x <= '1;
            r_goal_y <= '1;
        end else if (i_cfg_we && !i_cfg_sel) begin
            r_goal_x <= i_cfg_x;
            r_goal_y <= i_cfg_y;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid1 <= 1'b0;
            r_class1 <= CLS_STEP;
            r_nx1    <= '0;
            r_ny1    <= '0;
            r_sval1  <= '0;
        end else if (w_en) begin
            r_valid1 <= i_valid;
            if (i_valid) begin
                r_class1 <= w_class;
                r_nx1    <= w_next_x;
                r_ny1    <= w_next_y;
                r_sval1  <= w_cam_value;
            end
        end
    end

    always_comb begin
        case (r_class1)
            CLS_WALL:    w_reward = c_wall;
            CLS_GOAL:    w_reward = c_goal;
            CLS_SPECIAL: w_reward = r_sval1;
            default:     w_reward = c_step;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid2 <= 1'b0;
            r_class2 <= CLS_STEP;
            r_data2  <= '0;
            r_nx2    <= '0;
            r_ny2    <= '0;
        end else if (w_en) begin
            r_valid2 <= r_valid1;
            if (r_valid1) begin
                r_class2 <= r_class1;
                r_data2  <= w_reward;
                r_nx2    <= r_nx1;
                r_ny2    <= r_ny1;
            end
        end
    end

    assign o_valid  = r_valid2;
    assign o_data   = r_data2;
    assign o_class  = r_class2;
    assign o_next_x = r_nx2;
    assign o_next_y = r_ny2;

`ifdef RTABLE_GRID_STATS_EN
    logic        w_fire;
    logic [31:0] r_wall_cnt;
    logic [31:0] r_goal_cnt;

    assign w_fire = r_valid2 && i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wall_cnt <= '0;
            r_goal_cnt <= '0;
        end else if (w_fire) begin
            if ((r_class2 == CLS_WALL) && (r_wall_cnt != '1)) r_wall_cnt <= r_wall_cnt + 32'd1;
            if ((r_class2 == CLS_GOAL) && (r_goal_cnt != '1)) r_goal_cnt <= r_goal_cnt + 32'd1;
        end
    end

    assign o_wall_cnt = r_wall_cnt;
    assign o_goal_cnt = r_goal_cnt;
`else
    // Statistics counters are not built in this configuration
`endif

endmodule

`default_nettype wire

// File: tb/tb_rtable_grid.sv
// ============================================================================
// Module      : tb_rtable_grid
// Description : Self-checking bench for rtable_grid with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtable_grid;

    localparam int c_ns = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [7:0]  i_x = '0;
    logic [7:0]  i_y = '0;
    logic [2:0]  i_action = '0;
    logic        i_ready = 1'b1;
    logic        i_cfg_we = 1'b0;
    logic        i_cfg_sel = 1'b0;
    logic [3:0]  i_cfg_idx = '0;
    logic [7:0]  i_cfg_x = '0;
    logic [7:0]  i_cfg_y = '0;
    logic [31:0] i_cfg_data = '0;
    logic        i_cfg_en = 1'b0;
    logic        o_valid;
    logic [31:0] o_data;
    logic [1:0]  o_class;
    logic [7:0]  o_next_x;
    logic [7:0]  o_next_y;

    always #5 clk = ~clk;

    rtable_grid dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_x        (i_x),
        .i_y        (i_y),
        .i_action   (i_action),
        .i_ready    (i_ready),
        .i_cfg_we   (i_cfg_we),
        .i_cfg_sel  (i_cfg_sel),
        .i_cfg_idx  (i_cfg_idx),
        .i_cfg_x    (i_cfg_x),
        .i_cfg_y    (i_cfg_y),
        .i_cfg_data (i_cfg_data),
        .i_cfg_en   (i_cfg_en),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_class    (o_class),
        .o_next_x   (o_next_x),
        .o_next_y   (o_next_y)
    );

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    typedef struct packed {
        int d;
        int c;
        int nx;
        int ny;
    } exp_t;

    exp_t exp_q[$];

    int m_gx, m_gy;
    int m_sx [c_ns];
    int m_sy [c_ns];
    int m_sv [c_ns];
    bit m_se [c_ns];
    int dxs [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    int dys [8] = '{0, -1, -1, -1, 0, 1, 1, 1};

    bit bp_mode = 1'b0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_gx = 255;
        m_gy = 255;
        for (int i = 0; i < c_ns; i++) begin
            m_sx[i] = 0; m_sy[i] = 0; m_sv[i] = 0; m_se[i] = 1'b0;
        end
    endtask

    function automatic exp_t model(input int x, input int y, input int a);
        exp_t e;
        int tx, ty;
        bit found;
        tx = x + dxs[a];
        ty = y + dys[a];
        if (tx < 0 || tx > 255 || ty < 0 || ty > 255) begin
            e.d = -255; e.c = 1; e.nx = x; e.ny = y;
        end else begin
            e.nx = tx; e.ny = ty; e.d = 0; e.c = 0;
            if (tx == m_gx && ty == m_gy && !(x == m_gx && y == m_gy)) begin
                e.d = 255; e.c = 2;
            end else begin
                found = 1'b0;
                for (int i = 0; i < c_ns; i++) begin
                    if (!found && m_se[i] && m_sx[i] == tx && m_sy[i] == ty) begin
                        found = 1'b1; e.d = m_sv[i]; e.c = 3;
                    end
                end
            end
        end
        return e;
    endfunction

    // Compare process: scoreboard at every handshake plus stall stability
    initial begin
        bit   prev_stall;
        exp_t e;
        logic [31:0] h_data;
        logic [1:0]  h_class;
        logic [7:0]  h_nx, h_ny;
        prev_stall = 1'b0;
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                model_reset();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", int'(o_valid), 1);
                    chk("hold_data", int'($signed(o_data)), int'($signed(h_data)));
                    chk("hold_class", int'(o_class), int'(h_class));
                    chk("hold_nx", int'(o_next_x), int'(h_nx));
                    chk("hold_ny", int'(o_next_y), int'(h_ny));
                end
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("model_data", int'($signed(o_data)), e.d);
                        chk("model_class", int'(o_class), e.c);
                        chk("model_nx", int'(o_next_x), e.nx);
                        chk("model_ny", int'(o_next_y), e.ny);
                    end
                    n_out++;
                end
                if (i_valid && o_ready)
                    exp_q.push_back(model(int'(i_x), int'(i_y), int'(i_action)));
                if (i_cfg_we) begin
                    if (!i_cfg_sel) begin
                        m_gx = int'(i_cfg_x);
                        m_gy = int'(i_cfg_y);
                    end else if (int'(i_cfg_idx) < c_ns) begin
                        m_sx[i_cfg_idx] = int'(i_cfg_x);
                        m_sy[i_cfg_idx] = int'(i_cfg_y);
                        m_sv[i_cfg_idx] = int'($signed(i_cfg_data));
                        m_se[i_cfg_idx] = i_cfg_en;
                    end
                end
                prev_stall = o_valid && !i_ready;
                h_data = o_data; h_class = o_class; h_nx = o_next_x; h_ny = o_next_y;
            end
        end
    end

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                i_ready = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                i_ready = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic send(input int x, input int y, input int a);
        bit done;
        done = 1'b0;
        i_valid  = 1'b1;
        i_x      = 8'(x);
        i_y      = 8'(y);
        i_action = 3'(a);
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (o_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) chk("send_timeout", 0, 1);
        i_valid = 1'b0;
    endtask

    task automatic expect_out(input string nm, input int d, input int c, input int nx, input int ny);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (o_valid) got = 1'b1;
        end
        chk({nm, "_latency"}, lat, 2);
        chk({nm, "_data"}, int'($signed(o_data)), d);
        chk({nm, "_class"}, int'(o_class), c);
        chk({nm, "_nx"}, int'(o_next_x), nx);
        chk({nm, "_ny"}, int'(o_next_y), ny);
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string nm, input int x, input int y, input int a,
                          input int d, input int c, input int nx, input int ny);
        send(x, y, a);
        expect_out(nm, d, c, nx, ny);
    endtask

    task automatic cfg_write(input bit sel, input int idx, input int x, input int y,
                             input int data, input bit en);
        i_cfg_we   = 1'b1;
        i_cfg_sel  = sel;
        i_cfg_idx  = 4'(idx);
        i_cfg_x    = 8'(x);
        i_cfg_y    = 8'(y);
        i_cfg_data = 32'(data);
        i_cfg_en   = en;
        @(posedge clk);
        #1;
        i_cfg_we = 1'b0;
    endtask

    initial begin
        int wa [4] = '{0, 1, 2, 7};
        int n0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_data", int'(o_data), 0);
        chk("rst_class", int'(o_class), 0);
        chk("rst_nx", int'(o_next_x), 0);
        chk("rst_ny", int'(o_next_y), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", int'(o_ready), 1);

        for (int i = 0; i < 4; i++)
            lookup("corner_wall", 0, 0, wa[i], -255, 1, 0, 0);
        lookup("corner_east", 0, 0, 4, 0, 0, 1, 0);

        lookup("goal_e", 254, 255, 4, 255, 2, 255, 255);
        lookup("goal_s", 255, 254, 6, 255, 2, 255, 255);
        lookup("goal_se", 254, 254, 5, 255, 2, 255, 255);
        lookup("goal_wall", 255, 255, 4, -255, 1, 255, 255);

        // Goal write with a lookup accepted in the same cycle
        i_cfg_we = 1'b1; i_cfg_sel = 1'b0; i_cfg_x = 8'd10; i_cfg_y = 8'd10;
        i_valid = 1'b1; i_x = 8'd254; i_y = 8'd255; i_action = 3'd4;
        @(negedge clk);
        chk("samecycle_ready", int'(o_ready), 1);
        @(posedge clk);
        #1;
        i_cfg_we = 1'b0;
        i_valid  = 1'b0;
        expect_out("samecycle_oldgoal", 255, 2, 255, 255);
        lookup("newgoal", 9, 10, 4, 255, 2, 10, 10);
        lookup("oldgoal_step", 254, 255, 4, 0, 0, 255, 255);

        cfg_write(1'b1, 0, 5, 5, 7, 1'b1);
        cfg_write(1'b1, 2, 5, 5, 9, 1'b1);
        lookup("special_lowidx", 4, 4, 5, 7, 3, 5, 5);
        cfg_write(1'b1, 0, 5, 5, 7, 1'b0);
        lookup("special_disabled", 4, 4, 5, 9, 3, 5, 5);
        cfg_write(1'b1, 4, 6, 6, 99, 1'b1);
        lookup("special_idx_ignored", 5, 6, 4, 0, 0, 6, 6);

        // Backpressure stream: order, count and stability checked by the model
        n0 = n_out;
        bp_mode = 1'b1;
        send(0, 0, 4);
        send(3, 3, 5);
        send(255, 0, 3);
        send(10, 9, 6);
        send(7, 7, 1);
        send(5, 4, 6);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        @(posedge clk);
        #1;
        bp_mode = 1'b0;
        i_ready = 1'b1;
        chk("bp_count", n_out - n0, 6);
        chk("bp_drained", exp_q.size(), 0);

        // Reset with two results in flight
        send(1, 1, 4);
        send(2, 2, 4);
        rst = 1'b1;
        #1;
        chk("midrst_valid", int'(o_valid), 0);
        chk("midrst_data", int'(o_data), 0);
        chk("midrst_nx", int'(o_next_x), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lookup("postrst_goal", 254, 255, 4, 255, 2, 255, 255);
        lookup("postrst_nospecial", 4, 4, 5, 0, 0, 5, 5);

        repeat (4) @(posedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rtable_grid.md
Name: rtable_grid

Overview:
- Parametrised, pipelined reward and transition unit for the 8-connected grid-world Q-learning datapath; successor to the fixed-size ROM reward table.
- Takes a (x, y, action) lookup and returns the signed reward, reward class and next state.
- Goal cell and up to NUM_SPECIAL extra reward cells are programmable at runtime.
- Sits between the action selector and the Q-update pipeline; valid/ready on both sides.

Parameters:
- X_BITS, 8, column index width; grid width = 2^X_BITS.
- Y_BITS, 8, row index width; grid height = 2^Y_BITS.
- DATA_WIDTH, 32, signed reward width.
- NUM_SPECIAL, 4, programmable special-cell entries (1..16).
- WALL_REWARD, -255, reward for a move that would leave the grid.
- GOAL_REWARD, 255, reward for a move that lands on the goal.
- STEP_REWARD, 0, reward for any other move.

Ports:
- i_clk in 1: clock.
- i_rst in 1: asynchronous reset, active-high.
- i_valid in 1: lookup request valid.
- o_ready out 1: lookup accepted when i_valid && o_ready.
- i_x in X_BITS: current column.
- i_y in Y_BITS: current row.
- i_action in 3: action code.
- o_valid out 1: result valid.
- i_ready in 1: downstream accepts the result.
- o_data out DATA_WIDTH: signed reward.
- o_class out 2: 0 step, 1 wall, 2 goal, 3 special.
- o_next_x out X_BITS: next column.
- o_next_y out Y_BITS: next row.
- i_cfg_we in 1: configuration write strobe.
- i_cfg_sel in 1: 0 = goal register, 1 = special entry.
- i_cfg_idx in 4: special entry index.
- i_cfg_x in X_BITS: configured cell column.
- i_cfg_y in Y_BITS: configured cell row.
- i_cfg_data in DATA_WIDTH: special reward value.
- i_cfg_en in 1: special entry enable.

Behaviour:
- Action encoding, as (dx, dy) with y increasing downward: 0 W(-1,0), 1 NW(-1,-1), 2 N(0,-1), 3 NE(+1,-1), 4 E(+1,0), 5 SE(+1,+1), 6 S(0,+1), 7 SW(-1,+1).
- Wall condition: dx=-1 with x=0, or dx=+1 with x=max, or dy=-1 with y=0, or dy=+1 with y=max.
  - On a wall, next state = current state; there is no wrap-around.
- Otherwise next = (x+dx, y+dy).
- Classification priority is wall > goal > special > step:
  - goal: next == goal and current != goal.
  - special: next matches an enabled entry; the lowest index wins.
- Reward parameters are sign-extended to DATA_WIDTH.
- Pipeline: 2 stages, latency 2 cycles from acceptance to o_valid.
  - Stage 1 decodes the move and registers the class and match flags.
  - Stage 2 registers the reward and next state.
- Advance enable = !o_valid || i_ready; o_ready = enable.
- While o_valid && !i_ready, all outputs hold stable and no request is accepted.
- Full throughput: one lookup per cycle when i_ready is held high.
- A bubble in stage 1 propagates as o_valid=0; stage 2 still drains when enabled.
- Config writes are ignored when i_cfg_idx >= NUM_SPECIAL. They are never blocked by backpressure.
- A write in cycle N affects only lookups accepted in cycle N+1 or later. A lookup accepted in the same cycle as the write sees the old value.
- Reset (asynchronous, may occur mid-operation):
  - o_valid=0, pipeline flushed.
  - o_data=0, o_class=0, o_next_x=0, o_next_y=0.
  - goal = (2^X_BITS-1, 2^Y_BITS-1).
  - all special entries disabled with value 0.
- o_ready is combinational from o_valid/i_ready and is 1 after reset.

Optional Feature:
- RTABLE_GRID_STATS_EN: when defined, two extra output ports are added.
  - o_wall_cnt (32 bits) and o_goal_cnt (32 bits) count results of that class at stage-2 handshake (o_valid && i_ready).
  - Counts saturate at all-ones and reset to 0.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package rtable_pkg holds:
  - action code constants and the dx/dy lookup function;
  - the 2-bit class enum;
  - the default reward constants.
- Sub-module rtable_special_cam holds the NUM_SPECIAL config registers and a parallel match with lowest-index priority. It outputs a hit flag and the selected value.

Test Plan:
- Corner (0,0) with actions 0, 1, 2, 7 -> o_data=-255, class 1, next=(0,0). Action 4 -> data 0, next=(1,0).
- Default goal: (254,255) a=4 -> 255, class 2. (255,254) a=6 -> 255. (254,254) a=5 -> 255. (255,255) a=4 -> wall, -255.
- Write goal=(10,10), then (9,10) a=4 -> 255.
  - Old goal approach (254,255) a=4 -> 0.
  - Lookup accepted in the write cycle -> old goal still applies.
- Special entries 0 and 2 both set to (5,5), values 7 and 9; (4,4) a=5 -> 7, class 3. Disable entry 0 -> 9.
- Backpressure: stream 6 lookups with i_ready toggling 1,0,0,1 -> outputs arrive in order, none dropped or duplicated, outputs held stable while stalled.
- Assert i_rst with 2 results in flight -> o_valid=0 immediately, then the first post-reset lookup returns with latency 2 against default configuration.
